// File: rtl/reduce_tree_pipe.sv
// rtl/reduce_tree_pipe.sv - pipelined balanced-tree AND/OR/XOR reduction of a WIDTH-bit bus
// with elastic valid/ready stages; the optional inversion is applied in the last stage only.
module reduce_tree_pipe #(
    parameter int WIDTH      = 16,
    parameter int PIPE_EVERY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic [2:0]       out_op
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int NPAD   = 1 << LEVELS;
    localparam int S      = (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;

    logic [S-1:0]    v_q, v_d, ld;
    logic [NPAD-1:0] data_q [S];
    logic [NPAD-1:0] data_d [S];
    logic [2:0]      op_q   [S];
    logic [2:0]      op_d   [S];
    logic [NPAD-1:0] leaves;
    logic            any_empty;

    function automatic logic gate2(input logic a, input logic b, input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b10:   return a ^ b;
            default: return a | b;
        endcase
    endfunction

    // Each pass halves the live element count; partials stay packed in the low bits.
    function automatic logic [NPAD-1:0] reduce_levels(input logic [NPAD-1:0] vec,
                                                      input logic [1:0] op,
                                                      input int first_lev,
                                                      input int last_lev);
        logic [NPAD-1:0] cur;
        logic [NPAD-1:0] nxt;
        int              cnt;
        cur = vec;
        for (int l = 0; l < LEVELS; l++) begin
            if (l >= first_lev && l < last_lev) begin
                cnt = NPAD >> (l + 1);
                nxt = '0;
                for (int i = 0; i < NPAD / 2; i++) begin
                    if (i < cnt) begin
                        nxt[i] = gate2(cur[2*i], cur[2*i+1], op);
                    end
                end
                cur = nxt;
            end
        end
        return cur;
    endfunction

    function automatic logic [NPAD-1:0] stage_eval(input logic [NPAD-1:0] src,
                                                   input logic [2:0] op,
                                                   input int k);
        logic [NPAD-1:0] r;
        int              lo;
        int              hi;
        lo = k * PIPE_EVERY;
        hi = (lo + PIPE_EVERY < LEVELS) ? lo + PIPE_EVERY : LEVELS;
        r  = reduce_levels(src, op[1:0], lo, hi);
        if (k == S - 1) begin
            r[0] = r[0] ^ op[2];
        end
        return r;
    endfunction

    // A stage may load if it or any stage downstream of it has room, or the sink is taking.
    always_comb begin
        any_empty = out_ready;
        ld        = '0;
        for (int k = S - 1; k >= 0; k--) begin
            any_empty = any_empty | ~v_q[k];
            ld[k]     = any_empty;
        end
    end

    always_comb begin
        leaves              = {NPAD{in_op[1:0] == 2'b00}};
        leaves[WIDTH-1:0]   = in_data;
        in_ready            = rst_n & ~flush & ld[0];
        v_d                 = v_q;
        data_d              = data_q;
        op_d                = op_q;

        if (flush) begin
            v_d[0] = 1'b0;
        end else if (ld[0]) begin
            v_d[0] = in_valid;
        end
        if (in_ready && in_valid) begin
            data_d[0] = stage_eval(leaves, in_op, 0);
            op_d[0]   = in_op;
        end

        for (int k = 1; k < S; k++) begin
            if (flush) begin
                v_d[k] = 1'b0;
            end else if (ld[k]) begin
                v_d[k] = v_q[k-1];
            end
            if (!flush && ld[k] && v_q[k-1]) begin
                data_d[k] = stage_eval(data_q[k-1], op_q[k-1], k);
                op_d[k]   = op_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < S; k++) begin
                data_q[k] <= '0;
                op_q[k]   <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < S; k++) begin
                data_q[k] <= data_d[k];
                op_q[k]   <= op_d[k];
            end
        end
    end

    assign out_valid = v_q[S-1];
    assign out_data  = data_q[S-1][0];
    assign out_op    = op_q[S-1];

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// tb/tb_reduce_tree_pipe.sv - bench for reduce_tree_pipe: three geometries driven in parallel,
// table vectors, directed stall/flush/reset sequences and a random scoreboarded stream.
module tb_reduce_tree_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [15:0] in_data;
    logic [2:0]  in_op;
    logic [2:0]  in_ready_w, out_valid_w, out_data_w;
    logic [2:0]  out_op_w [3];

    always #5 clk = ~clk;

    reduce_tree_pipe #(.WIDTH(4), .PIPE_EVERY(1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data[3:0]), .in_op(in_op),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]), .out_op(out_op_w[0]));

    reduce_tree_pipe #(.WIDTH(16), .PIPE_EVERY(1)) u_w16 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data), .in_op(in_op),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]), .out_op(out_op_w[1]));

    reduce_tree_pipe #(.WIDTH(5), .PIPE_EVERY(2)) u_w5 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[2]), .in_data(in_data[4:0]), .in_op(in_op),
        .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_data(out_data_w[2]), .out_op(out_op_w[2]));

    typedef struct {
        logic       d;
        logic [2:0] op;
        int         cyc;
    } exp_t;

    typedef struct {
        int          inst;
        logic [15:0] d;
        logic [2:0]  op;
        logic        e;
    } vec_t;

    exp_t exp_q [3][$];
    logic got_q [3][$];
    vec_t tbl [$];
    int   pop_cnt [3];
    int   cyc = 0;
    bit   lat_chk;
    int   total = 0;
    int   bad = 0;
    exp_t e, ne;

    function automatic int w_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 16 : 5;
    endfunction

    // Stage counts: ceil(clog2(W)/PIPE_EVERY) -> W4/1:2, W16/1:4, W5/2:2.
    function automatic int s_of(input int i);
        return (i == 1) ? 4 : 2;
    endfunction

    function automatic logic ref_red(input logic [15:0] d, input logic [2:0] op, input int w);
        logic [31:0] mm;
        logic [15:0] x;
        logic        r;
        mm = (32'h1 << w) - 32'h1;
        x  = d & mm[15:0];
        case (op[1:0])
            2'b00:   r = (x == mm[15:0]);
            2'b10:   r = ^x;
            default: r = |x;
        endcase
        return r ^ op[2];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input int inst, input logic [15:0] d, input logic [2:0] op, input logic ex);
        vec_t v;
        v.inst = inst;
        v.d    = d;
        v.op   = op;
        v.e    = ex;
        tbl.push_back(v);
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (out_valid_w[i] && out_ready) begin
                if (exp_q[i].size() == 0) begin
                    chk($sformatf("unexpected_out_i%0d", i), 1, 0);
                end else begin
                    e = exp_q[i].pop_front();
                    chk($sformatf("sb_data_i%0d", i), 32'(out_data_w[i]), 32'(e.d));
                    chk($sformatf("sb_op_i%0d", i), 32'(out_op_w[i]), 32'(e.op));
                    if (lat_chk) chk($sformatf("latency_i%0d", i), cyc - e.cyc, s_of(i));
                end
                got_q[i].push_back(out_data_w[i]);
                pop_cnt[i]++;
            end
            if (in_valid && in_ready_w[i]) begin
                ne.d   = ref_red(in_data, in_op, w_of(i));
                ne.op  = in_op;
                ne.cyc = cyc;
                exp_q[i].push_back(ne);
            end
            if (flush || !rst_n) exp_q[i].delete();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          a [3];
        int          sent0, p0, nv;
        bit          nxt;
        logic        snap_d [3];
        logic [2:0]  snap_op [3];
        int          pb [3];

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_op = '0; lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) pop_cnt[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid_w), 0);
        chk("rst_out_data", 32'(out_data_w), 0);
        for (int i = 0; i < 3; i++) chk($sformatf("rst_out_op_i%0d", i), 32'(out_op_w[i]), 0);
        chk("rst_in_ready", 32'(in_ready_w), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready_w), 7);

        add(0, 16'h0008, 3'b101, 1'b0); add(0, 16'h0000, 3'b101, 1'b1);
        add(0, 16'h0004, 3'b101, 1'b0); add(0, 16'h0000, 3'b101, 1'b1);
        add(0, 16'h0002, 3'b101, 1'b0); add(0, 16'h0000, 3'b101, 1'b1);
        add(0, 16'h0001, 3'b101, 1'b0); add(0, 16'h0000, 3'b101, 1'b1);
        add(1, 16'hFFFF, 3'b000, 1'b1); add(1, 16'hFFFE, 3'b000, 1'b0);
        add(1, 16'hFFFF, 3'b100, 1'b0); add(1, 16'hFFFE, 3'b100, 1'b1);
        add(1, 16'h0007, 3'b010, 1'b1); add(1, 16'h0003, 3'b110, 1'b1);
        add(2, 16'h001F, 3'b000, 1'b1); add(2, 16'h0000, 3'b001, 1'b0);
        add(2, 16'h0010, 3'b010, 1'b1); add(2, 16'hFFE0, 3'b000, 1'b0);
        add(2, 16'h0004, 3'b011, 1'b1); add(0, 16'h000F, 3'b110, 1'b1);

        for (int i = 0; i < 3; i++) got_q[i].delete();
        for (int j = 0; j < tbl.size(); j++) begin
            @(posedge clk);
            #1 in_valid = 1'b1; in_data = tbl[j].d; in_op = tbl[j].op;
        end
        @(posedge clk);
        #1 idle(10);
        for (int j = 0; j < tbl.size(); j++) begin
            if (got_q[tbl[j].inst].size() > j)
                chk($sformatf("tbl%0d_i%0d", j, tbl[j].inst), 32'(got_q[tbl[j].inst][j]), 32'(tbl[j].e));
            else
                chk($sformatf("tbl%0d_missing", j), 0, 1);
        end

        // Backpressure: sink stalls for 6 cycles while the source keeps streaming.
        lat_chk = 1'b0;
        p0 = pop_cnt[0];
        sent0 = 0; nxt = 1'b1;
        for (int i = 0; i < 3; i++) a[i] = 0;
        for (int c = 0; c < 200 && sent0 < 8; c++) begin
            @(posedge clk);
            #1 out_ready = (c >= 6); in_valid = 1'b1;
            if (nxt) begin in_data = 16'($urandom); in_op = 3'($urandom); end
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (c < 6 && in_ready_w[i]) a[i]++;
            if (c == 4) begin
                chk("stall_out_valid", 32'(out_valid_w), 7);
                for (int i = 0; i < 3; i++) begin snap_d[i] = out_data_w[i]; snap_op[i] = out_op_w[i]; end
            end
            if (c == 5) begin
                chk("stall_in_ready", 32'(in_ready_w), 0);
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("stall_accepts_i%0d", i), a[i], s_of(i));
                    chk($sformatf("stall_hold_data_i%0d", i), 32'(out_data_w[i]), 32'(snap_d[i]));
                    chk($sformatf("stall_hold_op_i%0d", i), 32'(out_op_w[i]), 32'(snap_op[i]));
                end
            end
            nxt = in_ready_w[0];
            if (in_ready_w[0]) sent0++;
        end
        chk("stall_sent_all", sent0, 8);
        @(posedge clk);
        #1 idle(20);
        chk("stall_delivered", pop_cnt[0] - p0, 8);
        lat_chk = 1'b1;

        // Flush with three beats in flight; a fourth beat is presented during the flush.
        for (int b = 0; b < 3; b++) begin
            @(posedge clk);
            #1 in_valid = 1'b1; in_data = 16'($urandom); in_op = 3'($urandom);
        end
        @(posedge clk);
        #1 flush = 1'b1; in_data = 16'($urandom);
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready_w), 0);
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid_w), 0);
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid_w != 3'b000) nv++;
        end
        chk("flush_no_stale", nv, 0);

        // Asynchronous reset in the middle of a stream.
        for (int b = 0; b < 5; b++) begin
            @(posedge clk);
            #1 in_valid = 1'b1; in_data = 16'($urandom); in_op = 3'($urandom);
        end
        @(posedge clk);
        #3 rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid_w), 0);
        chk("midrst_out_data", 32'(out_data_w), 0);
        for (int i = 0; i < 3; i++) chk($sformatf("midrst_out_op_i%0d", i), 32'(out_op_w[i]), 0);
        chk("midrst_in_ready", 32'(in_ready_w), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_in_ready", 32'(in_ready_w), 7);
        for (int i = 0; i < 3; i++) pb[i] = pop_cnt[i];
        @(posedge clk);
        #1 in_valid = 1'b1; in_data = 16'h0015; in_op = 3'b010;
        @(posedge clk);
        #1 idle(8);
        for (int i = 0; i < 3; i++) chk($sformatf("midrst_one_result_i%0d", i), pop_cnt[i] - pb[i], 1);

        // Random traffic with random backpressure and occasional flushes.
        lat_chk = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            in_op     = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
        end
        @(posedge clk);
        #1 idle(12);
        for (int i = 0; i < 3; i++) chk($sformatf("drain_empty_i%0d", i), exp_q[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
